// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the core/host data memory arbiter.
// FSM encodings, bus widths and the default host starvation limit.
package bat_mem_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned WW = 4;

    localparam int unsigned MAX_WAIT_DEF = 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;

    function automatic mem_req_t pick_req(
        input logic     sel_host,
        input mem_req_t host_r,
        input mem_req_t core_r
    );
        return sel_host ? host_r : core_r;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Core, host and memory signal bundle for the data memory arbiter.
// slave = arbiter side, master = environment side.
interface data_mem_arbiter_if;
    import bat_mem_pkg::*;

    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_clk_en;

    logic          host_req;
    logic          host_we;
    logic          host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_clk_en,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_clk_en,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one synchronous data memory between the core and a host port.
// Core has priority; the host is guaranteed a slot after MAX_WAIT cycles.
module data_mem_arbiter
    import bat_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                sync_rst,
    input  logic                clk_en,
    data_mem_arbiter_if.slave   bus
);

    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          rd_pend_q, rd_pend_d;

    logic          host_pending;
    logic          grant_host;
    logic          grant_core;
    logic          rd_take;
    mem_req_t      core_r;
    mem_req_t      host_r;
    mem_req_t      sel_r;

    always_comb begin
        host_pending = bus.host_req && (state_q == S_IDLE) && !sync_rst;
        grant_host   = host_pending &&
                       (!bus.core_req || (wait_q == WAIT_LIM) || bus.host_lock);
        grant_core   = bus.core_req && !grant_host &&
                       !bus.host_lock && !sync_rst;
    end

    always_comb begin
        core_r = '{we: bus.core_we, addr: bus.core_addr, wdata: bus.core_wdata};
        host_r = '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};
        sel_r  = pick_req(grant_host, host_r, core_r);
    end

    always_comb begin
        bus.mem_en    = clk_en && (grant_host || grant_core);
        bus.mem_we    = bus.mem_en && sel_r.we;
        bus.mem_addr  = sel_r.addr;
        bus.mem_wdata = sel_r.wdata;
    end

    // During reset the core must keep clocking so it sees its own reset.
    always_comb begin
        bus.core_clk_en = clk_en &&
                          (sync_rst ||
                           (!bus.host_lock && !(bus.core_req && !grant_core)));
    end

    always_comb begin
        bus.host_ack   = clk_en && !sync_rst && (state_q == S_ACK);
        bus.host_rdata = bus.host_ack ? bus.mem_rdata : '0;
    end

    // Fresh read data is only on mem_rdata for one enabled cycle; the hold
    // register keeps it visible to the core across later stalls.
    always_comb begin
        rd_take        = clk_en && rd_pend_q && !sync_rst;
        bus.core_rdata = rd_take ? bus.mem_rdata : hold_q;
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        hold_d    = hold_q;
        rd_pend_d = rd_pend_q;
        if (clk_en) begin
            unique case (1'b1)
                (state_q == S_IDLE): if (grant_host) state_d = S_ACK;
                (state_q == S_ACK):  state_d = S_IDLE;
                default:             state_d = S_IDLE;
            endcase
            if (grant_host || !bus.host_req) begin
                wait_d = '0;
            end else if (host_pending && (wait_q < WAIT_LIM)) begin
                wait_d = wait_q + 1'b1;
            end
            rd_pend_d = grant_core && !bus.core_we;
            if (rd_pend_q) hold_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            hold_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a host read-data scoreboard.
// A behavioural synchronous RAM sits on the memory side.
module tb_data_mem_arbiter;
    import bat_mem_pkg::*;

    logic clk = 1'b0;
    logic sync_rst;
    logic clk_en;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.MAX_WAIT(3)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [8:0] host_q  [$];
    int         vectors = 0;
    int         errors  = 0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.host_ack === 1'b1) begin
            if (host_q.size() == 0) begin
                check("ack_unexp", 32'(bus.host_ack), 0);
            end else begin
                logic [8:0] e;
                e = host_q.pop_front();
                if (e[8]) check("host_rdata", 32'(bus.host_rdata), 32'(e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input logic req, input logic we,
                              input logic [7:0] a, input logic [7:0] d);
        bus.core_req   = req;
        bus.core_we    = we;
        bus.core_addr  = a;
        bus.core_wdata = d;
    endtask

    task automatic drive_host(input logic req, input logic we, input logic lock,
                              input logic [7:0] a, input logic [7:0] d);
        bus.host_req   = req;
        bus.host_we    = we;
        bus.host_lock  = lock;
        bus.host_addr  = a;
        bus.host_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[8'h10]     = 8'h5A;
        ref_mem[8'h10] = 8'h5A;
        bus.mem_rdata  = '0;
        drive_core(0, 0, 0, 0);
        drive_host(0, 0, 0, 0, 0);
        sync_rst = 1'b1;
        clk_en   = 1'b1;

        // reset: core keeps its clock, no grants
        tick();
        tick();
        drive_core(1, 0, 8'h33, 0);
        @(negedge clk);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_cke", 32'(bus.core_clk_en), 1);
        check("rst_ack", 32'(bus.host_ack), 0);
        clk_en = 1'b0;
        #1;
        check("rst_cke_off", 32'(bus.core_clk_en), 0);
        tick();
        sync_rst = 1'b0;
        clk_en   = 1'b1;
        drive_core(0, 0, 0, 0);
        @(negedge clk);
        check("rst_rdata", 32'(bus.core_rdata), 0);
        check("idle_cke", 32'(bus.core_clk_en), 1);

        // plain core read
        tick();
        drive_core(1, 0, 8'h10, 0);
        @(negedge clk);
        check("c_rd_en", 32'(bus.mem_en), 1);
        check("c_rd_addr", 32'(bus.mem_addr), 32'h10);
        check("c_rd_cke", 32'(bus.core_clk_en), 1);
        tick();
        drive_core(0, 0, 0, 0);
        @(negedge clk);
        check("c_rdata", 32'(bus.core_rdata), 32'(ref_mem[8'h10]));
        check("c_en_off", 32'(bus.mem_en), 0);
        check("c_cke2", 32'(bus.core_clk_en), 1);
        tick();
        @(negedge clk);
        check("c_hold", 32'(bus.core_rdata), 32'(ref_mem[8'h10]));

        // starvation limit
        tick();
        drive_core(1, 0, 8'h20, 0);
        drive_host(1, 0, 0, 8'h30, 0);
        host_q.push_back({1'b1, ref_mem[8'h30]});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("starve_addr", 32'(bus.mem_addr), 32'h20);
            check("starve_cke", 32'(bus.core_clk_en), 1);
            tick();
        end
        @(negedge clk);
        check("hgrant_addr", 32'(bus.mem_addr), 32'h30);
        check("hgrant_cke", 32'(bus.core_clk_en), 0);
        tick();
        @(negedge clk);
        check("hack", 32'(bus.host_ack), 1);
        check("hack_crdata", 32'(bus.core_rdata), 32'(ref_mem[8'h20]));
        check("hack_cke", 32'(bus.core_clk_en), 1);
        tick();
        @(negedge clk);
        check("wclr_addr", 32'(bus.mem_addr), 32'h20);
        check("wclr_cke", 32'(bus.core_clk_en), 1);
        tick();
        drive_core(0, 0, 0, 0);
        drive_host(0, 0, 0, 0, 0);

        // locked host write then read back
        drive_core(1, 0, 8'h11, 0);
        drive_host(1, 1, 1, 8'h40, 8'h22);
        host_q.push_back(9'h000);
        ref_mem[8'h40] = 8'h22;
        @(negedge clk);
        check("lk_we", 32'(bus.mem_we), 1);
        check("lk_wdata", 32'(bus.mem_wdata), 32'h22);
        check("lk_cke0", 32'(bus.core_clk_en), 0);
        tick();
        drive_host(1, 0, 1, 8'h40, 0);
        host_q.push_back({1'b1, ref_mem[8'h40]});
        @(negedge clk);
        check("lk_ack1", 32'(bus.host_ack), 1);
        check("lk_cke1", 32'(bus.core_clk_en), 0);
        tick();
        @(negedge clk);
        check("lk_rd_en", 32'(bus.mem_en), 1);
        check("lk_rd_we", 32'(bus.mem_we), 0);
        check("lk_cke2", 32'(bus.core_clk_en), 0);
        tick();
        drive_host(0, 0, 1, 0, 0);
        @(negedge clk);
        check("lk_ack2", 32'(bus.host_ack), 1);
        check("lk_cke3", 32'(bus.core_clk_en), 0);
        tick();
        drive_core(0, 0, 0, 0);
        drive_host(0, 0, 0, 0, 0);

        // host steals right after a core read grant
        drive_core(1, 0, 8'h50, 0);
        @(negedge clk);
        check("st_grant", 32'(bus.mem_addr), 32'h50);
        tick();
        drive_host(1, 0, 1, 8'h60, 0);
        host_q.push_back({1'b1, ref_mem[8'h60]});
        @(negedge clk);
        check("st_cke", 32'(bus.core_clk_en), 0);
        check("st_cap", 32'(bus.core_rdata), 32'(ref_mem[8'h50]));
        tick();
        drive_host(0, 0, 1, 0, 0);
        @(negedge clk);
        check("st_hold1", 32'(bus.core_rdata), 32'(ref_mem[8'h50]));
        check("st_cke1", 32'(bus.core_clk_en), 0);
        tick();
        drive_host(0, 0, 0, 0, 0);
        @(negedge clk);
        check("st_hold2", 32'(bus.core_rdata), 32'(ref_mem[8'h50]));
        check("st_resume", 32'(bus.core_clk_en), 1);
        tick();
        drive_core(0, 0, 0, 0);

        // clock-enable stall while in the ack state
        drive_host(1, 0, 0, 8'h70, 0);
        host_q.push_back({1'b1, ref_mem[8'h70]});
        @(negedge clk);
        check("ce_grant", 32'(bus.mem_en), 1);
        tick();
        clk_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("ce_ack_off", 32'(bus.host_ack), 0);
            check("ce_en_off", 32'(bus.mem_en), 0);
            check("ce_cke_off", 32'(bus.core_clk_en), 0);
            tick();
        end
        clk_en = 1'b1;
        drive_host(0, 0, 0, 0, 0);
        @(negedge clk);
        check("ce_ack_on", 32'(bus.host_ack), 1);
        tick();
        @(negedge clk);
        check("ce_once", 32'(bus.host_ack), 0);
        tick();

        // reset lands in the ack state
        drive_host(1, 0, 0, 8'h80, 0);
        @(negedge clk);
        check("rs_grant", 32'(bus.mem_en), 1);
        tick();
        sync_rst = 1'b1;
        drive_host(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rs_ack", 32'(bus.host_ack), 0);
        check("rs_hrdata", 32'(bus.host_rdata), 0);
        check("rs_cke", 32'(bus.core_clk_en), 1);
        check("rs_en", 32'(bus.mem_en), 0);
        check("rs_we", 32'(bus.mem_we), 0);
        tick();
        sync_rst = 1'b0;
        @(negedge clk);
        check("rs_ack2", 32'(bus.host_ack), 0);
        check("rs_hold", 32'(bus.core_rdata), 0);
        tick();

        check("sb_empty", 32'(host_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
